// File: rtl/ldo_ramp_seq_if.sv
// Register-file side bundle for the LDO handover sequencer: control/config in, thermometers and status out.
interface ldo_ramp_seq_if #(
  parameter int NCH   = 2,
  parameter int NSEG  = 64,
  parameter int CW    = 7,
  parameter int NALDO = 15,
  parameter int AW    = 4,
  parameter int TW    = 16
);
  logic                 cfg_en;
  logic                 start;
  logic                 dir;
  logic                 abort;
  logic [NCH*CW-1:0]    init_cnt;
  logic [CW-1:0]        step_size;
  logic [TW-1:0]        step_div;
  logic [TW-1:0]        settle_cyc;
  logic [AW-1:0]        aldo_target;
  logic [NCH*NSEG-1:0]  dldo_en_n;
  logic [NALDO-1:0]     aldo_en;
  logic                 busy;
  logic                 done;
  logic [2:0]           state_o;

  modport master (
    output cfg_en, start, dir, abort, init_cnt, step_size, step_div, settle_cyc, aldo_target,
    input  dldo_en_n, aldo_en, busy, done, state_o
  );

  modport slave (
    input  cfg_en, start, dir, abort, init_cnt, step_size, step_div, settle_cyc, aldo_target,
    output dldo_en_n, aldo_en, busy, done, state_o
  );
endinterface

// File: rtl/ldo_ramp_seq.sv
// ALDO/DLDO power-handover sequencer with thermometer outputs.
// Define LDO_STAGGER_EN to ramp channels one at a time instead of in lockstep.
module ldo_ramp_seq #(
  parameter int NCH   = 2,
  parameter int NSEG  = 64,
  parameter int CW    = 7,
  parameter int NALDO = 15,
  parameter int AW    = 4,
  parameter int TW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  ldo_ramp_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    RAMP_DN = 3'd2,
    HOLD    = 3'd3,
    RAMP_UP = 3'd4,
    POST    = 3'd5
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q  [NCH];
  logic [CW-1:0]       init_q [NCH];
  logic [AW-1:0]       aldo_cnt_q;
  logic [AW-1:0]       target_q;
  logic [CW-1:0]       step_q;
  logic [TW-1:0]       div_cfg_q;
  logic [TW-1:0]       settle_q;
  logic [TW-1:0]       div_q;
  logic [TW-1:0]       timer_q;
  logic                busy_q;
  logic                done_q;
  logic [NCH*NSEG-1:0] dldo_en_n_q;
  logic [NALDO-1:0]    aldo_en_q;

  logic [CW-1:0]       init_clamp_d [NCH];
  logic [CW-1:0]       dn_d [NCH];
  logic [CW-1:0]       up_d [NCH];
  logic                dn_zero_d;
  logic                up_full_d;
  logic                kill_d;
  logic                go_dn_d;
  logic                go_up_d;

  function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] v);
    return (int'(v) > NSEG) ? CW'(NSEG) : v;
  endfunction

  function automatic logic [AW-1:0] clamp_aldo(input logic [AW-1:0] v);
    return (int'(v) > NALDO) ? AW'(NALDO) : v;
  endfunction

  function automatic logic [CW-1:0] step_dn(input logic [CW-1:0] c, input logic [CW-1:0] s);
    return (c > s) ? c - s : '0;
  endfunction

  // Sum is one bit wider so a large step cannot wrap past the ceiling.
  function automatic logic [CW-1:0] step_up(input logic [CW-1:0] c, input logic [CW-1:0] s,
                                            input logic [CW-1:0] lim);
    logic [CW:0] sum;
    sum = {1'b0, c} + {1'b0, s};
    return (sum > {1'b0, lim}) ? lim : sum[CW-1:0];
  endfunction

  function automatic logic [NSEG-1:0] therm_seg(input logic [CW-1:0] c);
    logic [NSEG-1:0] t;
    for (int j = 0; j < NSEG; j++) t[j] = (int'(c) > j);
    return t;
  endfunction

  function automatic logic [NALDO-1:0] therm_aldo(input logic [AW-1:0] c);
    logic [NALDO-1:0] t;
    for (int j = 0; j < NALDO; j++) t[j] = (int'(c) > j);
    return t;
  endfunction

  assign kill_d  = bus.abort || !bus.cfg_en;
  assign go_dn_d = (state_q == IDLE) && bus.start && !bus.dir && !kill_d;
  assign go_up_d = (state_q == HOLD) && bus.start &&  bus.dir && !kill_d;

`ifdef LDO_STAGGER_EN
  logic dn_pick_d;
  logic up_pick_d;
`endif

  always_comb begin
    for (int i = 0; i < NCH; i++) init_clamp_d[i] = clamp_cnt(bus.init_cnt[i*CW +: CW]);
`ifdef LDO_STAGGER_EN
    // Down walks from channel 0 upward, up walks back from the top channel.
    dn_pick_d = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      dn_d[i] = cnt_q[i];
      if (!dn_pick_d && cnt_q[i] != '0) begin
        dn_d[i]   = step_dn(cnt_q[i], step_q);
        dn_pick_d = 1'b1;
      end
    end
    up_pick_d = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      up_d[i] = cnt_q[i];
      if (!up_pick_d && cnt_q[i] != init_q[i]) begin
        up_d[i]   = step_up(cnt_q[i], step_q, init_q[i]);
        up_pick_d = 1'b1;
      end
    end
`else
    for (int i = 0; i < NCH; i++) begin
      dn_d[i] = step_dn(cnt_q[i], step_q);
      up_d[i] = step_up(cnt_q[i], step_q, init_q[i]);
    end
`endif
    dn_zero_d = 1'b1;
    up_full_d = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (dn_d[i] != '0)        dn_zero_d = 1'b0;
      if (up_d[i] != init_q[i]) up_full_d = 1'b0;
    end
  end

  // Ramp configuration is frozen at each accepted start.
  always_ff @(posedge clk) begin
    if (go_dn_d || go_up_d) begin
      step_q    <= (bus.step_size == '0) ? CW'(1) : bus.step_size;
      div_cfg_q <= bus.step_div;
      settle_q  <= bus.settle_cyc;
    end
    if (go_dn_d) begin
      init_q   <= init_clamp_d;
      target_q <= clamp_aldo(bus.aldo_target);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '{default: '0};
      aldo_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_q      <= '0;
      timer_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (kill_d) begin
        state_q    <= IDLE;
        cnt_q      <= init_clamp_d;
        aldo_cnt_q <= '0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q      <= init_clamp_d;
            aldo_cnt_q <= '0;
            if (go_dn_d) begin
              state_q    <= PRE;
              busy_q     <= 1'b1;
              aldo_cnt_q <= clamp_aldo(bus.aldo_target);
              timer_q    <= bus.settle_cyc;
            end
          end
          PRE: begin
            if (timer_q <= TW'(1)) begin
              state_q <= RAMP_DN;
              div_q   <= '0;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          RAMP_DN: begin
            if (div_q == '0) begin
              cnt_q <= dn_d;
              div_q <= div_cfg_q;
              if (dn_zero_d) begin
                state_q <= HOLD;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              div_q <= div_q - TW'(1);
            end
          end
          HOLD: begin
            if (go_up_d) begin
              state_q <= RAMP_UP;
              busy_q  <= 1'b1;
              div_q   <= '0;
            end
          end
          RAMP_UP: begin
            if (div_q == '0) begin
              cnt_q <= up_d;
              div_q <= div_cfg_q;
              if (up_full_d) begin
                state_q <= POST;
                timer_q <= settle_q;
              end
            end else begin
              div_q <= div_q - TW'(1);
            end
          end
          POST: begin
            if (timer_q <= TW'(1)) begin
              state_q    <= IDLE;
              aldo_cnt_q <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Output register stage: thermometers lag the counts by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dldo_en_n_q <= '1;
      aldo_en_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) dldo_en_n_q[i*NSEG +: NSEG] <= ~therm_seg(cnt_q[i]);
      aldo_en_q <= therm_aldo(aldo_cnt_q);
    end
  end

  assign bus.dldo_en_n = dldo_en_n_q;
  assign bus.aldo_en   = aldo_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_ldo_ramp_seq.sv
// Directed bench for ldo_ramp_seq: handover, handback, abort, clamping and ignored-start cases.
module tb_ldo_ramp_seq;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cyc;

  ldo_ramp_seq_if bus ();

  ldo_ramp_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LDO_STAGGER_EN
  localparam int HOLD_DN  = 19;
  localparam int POST_UP  = 30;
  localparam int IDLE_UP  = 33;
  localparam int DN6_C1   = 20;
  localparam int UP4_C0   = 0;
  localparam int AB_C1    = 20;
`else
  localparam int HOLD_DN  = 14;
  localparam int POST_UP  = 20;
  localparam int IDLE_UP  = 23;
  localparam int DN6_C1   = 16;
  localparam int UP4_C0   = 4;
  localparam int AB_C1    = 4;
`endif

  function automatic logic [127:0] dldo_exp(input int c0, input int c1);
    logic [127:0] v;
    v = '1;
    for (int j = 0; j < 64; j++) begin
      if (j < c0) v[j] = 1'b0;
      if (j < c1) v[64+j] = 1'b0;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic go(input logic d);
    bus.start = 1'b1;
    bus.dir   = d;
    cyc       = 0;
    tick();
    bus.start = 1'b0;
    bus.dir   = 1'b0;
  endtask

  task automatic wait_state(input int s, input int lim);
    int n;
    n = 0;
    while (int'(bus.state_o) != s && n < lim) begin
      tick();
      n++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.cfg_en      = 1'b1;
    bus.start       = 1'b0;
    bus.dir         = 1'b0;
    bus.abort       = 1'b0;
    bus.init_cnt    = '0;
    bus.step_size   = 7'd4;
    bus.step_div    = 16'd0;
    bus.settle_cyc  = 16'd3;
    bus.aldo_target = 4'd10;

    // Reset and idle tracking
    tick();
    chk("rst_state", bus.state_o, 0);
    chk("rst_dldo", bus.dldo_en_n, {128{1'b1}});
    chk("rst_aldo", bus.aldo_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    tick();
    rst = 1'b0;
    bus.init_cnt = {7'd20, 7'd40};
    tick();
    tick();
    chk("idle_dldo", bus.dldo_en_n, {64'hFFFF_FFFF_FFF0_0000, 64'hFFFF_FF00_0000_0000});
    chk("idle_aldo", bus.aldo_en, 0);
    chk("idle_busy", bus.busy, 0);

    // Handover
    go(1'b0);
    chk("pre_state", bus.state_o, 1);
    chk("pre_busy", bus.busy, 1);
    chk("pre_aldo_lag", bus.aldo_en, 0);
    tick();
    chk("pre_aldo", bus.aldo_en, 15'h03FF);
    tick_to(3);
    chk("pre_c3", bus.state_o, 1);
    tick_to(4);
    chk("dn_entry", bus.state_o, 2);
    tick_to(6);
    chk("dn_c6_dldo", bus.dldo_en_n, dldo_exp(36, DN6_C1));
    wait_state(3, 100);
    chk("hold_cyc", cyc, HOLD_DN);
    chk("hold_done", bus.done, 1);
    chk("hold_busy", bus.busy, 0);
    tick();
    chk("hold_done_fall", bus.done, 0);
    chk("hold_dldo", bus.dldo_en_n, {128{1'b1}});
    chk("hold_aldo", bus.aldo_en, 15'h03FF);
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("hold_ign_dn", bus.state_o, 3);

    // Handback
    bus.step_div = 16'd1;
    go(1'b1);
    chk("up_entry", bus.state_o, 4);
    chk("up_busy", bus.busy, 1);
    tick_to(4);
    chk("up_c4_dldo", bus.dldo_en_n, dldo_exp(UP4_C0, 4));
    wait_state(5, 100);
    chk("post_cyc", cyc, POST_UP);
    tick();
    chk("post_dldo", bus.dldo_en_n, dldo_exp(40, 20));
    chk("post_aldo", bus.aldo_en, 15'h03FF);
    wait_state(0, 20);
    chk("idle_cyc", cyc, IDLE_UP);
    chk("idle_done", bus.done, 1);
    chk("idle_busy_fall", bus.busy, 0);
    tick();
    chk("idle_aldo_off", bus.aldo_en, 0);
    chk("idle_done_fall", bus.done, 0);
    go(1'b1);
    chk("idle_ign_up", bus.state_o, 0);
    chk("idle_ign_busy", bus.busy, 0);

    // Abort mid ramp-down, then the same via cfg_en
    bus.step_div = 16'd0;
    for (int k = 0; k < 2; k++) begin
      go(1'b0);
      tick_to(8);
      if (k == 0) bus.abort = 1'b1;
      else        bus.cfg_en = 1'b0;
      tick();
      bus.abort  = 1'b0;
      bus.cfg_en = 1'b1;
      chk("abort_state", bus.state_o, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_dldo_c8", bus.dldo_en_n, dldo_exp(24, AB_C1));
      tick();
      chk("abort_reload", bus.dldo_en_n, dldo_exp(40, 20));
      chk("abort_aldo", bus.aldo_en, 0);
      chk("abort_done2", bus.done, 0);
    end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_prio", bus.state_o, 0);
    chk("abort_prio_busy", bus.busy, 0);

    // Clamp, zero step, zero settle, ignored mid-ramp changes
    bus.init_cnt   = {7'd0, 7'd100};
    bus.step_size  = 7'd0;
    bus.settle_cyc = 16'd0;
    tick();
    tick();
    chk("clamp_idle", bus.dldo_en_n, dldo_exp(64, 0));
    go(1'b0);
    chk("b_pre", bus.state_o, 1);
    tick();
    chk("b_dn", bus.state_o, 2);
    tick_to(4);
    chk("b_c4_dldo", bus.dldo_en_n, dldo_exp(63, 0));
    tick_to(10);
    bus.start      = 1'b1;
    bus.step_size  = 7'd8;
    bus.init_cnt   = {7'd20, 7'd40};
    bus.settle_cyc = 16'd5;
    tick();
    bus.start = 1'b0;
    chk("b_ign_start", bus.state_o, 2);
    wait_state(3, 200);
    chk("b_hold_cyc", cyc, 66);
    chk("b_hold_done", bus.done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
